memory_block: RTL and testbench
===============================

// Module: memory_block
// PURPOSE
//   Single-port 128x8 synchronous RAM with a request/ready handshake, used as
//   the main store of the 8-bit CPU. A requester raises en with read or write
//   selected. The block performs the access after a fixed latency, then raises
//   ready. It holds ready until en is dropped (4-phase handshake).
// PARAMETERS
//   ADDR_WIDTH  7    address bits; DEPTH = 2**ADDR_WIDTH = 128 words
//   DATA_WIDTH  8    word width
//   LATENCY     1    clock cycles spent in BUSY before the access commits (>=1)
// PORTS
//   clk          in   1   system clock; all state changes on its rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   en           in   1   request; held high until ready is seen, then dropped
//   read         in   1   read select (sampled with en)
//   write        in   1   write select (sampled with en)
//   address      in   7   word address, 0..127
//   input_data   in   8   write data
//   output_data  out  8   read data; holds the last read value
//   ready        out  1   access complete; high in DONE only
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, ready=0, output_data=8'h00, and the
//     internal address/data/op registers are cleared. RAM contents are NOT
//     cleared by reset.
//   - FSM states: IDLE, BUSY, DONE.
//   - IDLE: on a clk edge with en=1 and exactly one of read/write set, latch
//     address, input_data and op, load the latency counter, and go to BUSY.
//     en=1 with read=write=1, or with read=write=0, is ignored: stay IDLE, no
//     access.
//   - BUSY: count LATENCY cycles.
//     On the last cycle:
//       - write: mem[addr] <= data.
//       - read: output_data <= mem[addr].
//     Then go to DONE and ready=1 (registered). With LATENCY=1, ready rises on
//     the second rising edge after en is first sampled high.
//   - Inputs are latched at request time. Changes to address, input_data,
//     read or write during BUSY/DONE have no effect.
//   - If en drops during BUSY, the access still completes and the FSM passes
//     through DONE for one cycle, then returns to IDLE.
//   - DONE: ready=1 while en=1. On the first edge with en=0, go to IDLE and
//     ready=0. A new request needs en low for at least one sampled edge.
//   - output_data changes only when a read commits. Writes never alter it.
//   - Address arithmetic: full 7-bit index, no wrap logic needed. Addresses 0
//     and 127 are both valid.
//   - Reset asserted mid-operation aborts it. A write not yet committed is
//     lost; one already committed persists.
//   - No combinational path from inputs to outputs.
// TESTING
//   1. Write: address=1, input_data=8'hFF, write=1, en held 3 cycles
//      -> ready=1 two edges after en sampled; stays 1 until en=0; then 0 next edge.
//   2. Read back: address=1, read=1, en held 2 cycles
//      -> ready=1 and output_data=8'hFF on second edge; ready=0 after en drops.
//   3. Boundaries: write 8'hA5 to address 0 and 8'h5A to address 127, read both
//      -> 8'hA5 and 8'h5A; other addresses unchanged.
//   4. Illegal select: en=1 with read=write=1 (and with both 0) for 4 cycles
//      -> ready stays 0, memory and output_data unchanged.
//   5. Input stability: change address/input_data during BUSY
//      -> the originally latched address/data are used.
//   6. Reset: assert rst_n=0 mid-BUSY of a write to address 3
//      -> ready=0 and output_data=0 immediately; address 3 keeps its old value.

Source files
------------

// File: rtl/memory_block.sv
// rtl/memory_block.sv - 128x8 single-port synchronous RAM with 4-phase en/ready handshake
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   request, held until ready is seen, then dropped
//   read         in   read select, sampled with en in IDLE
//   write        in   write select, sampled with en in IDLE
//   address      in   word address
//   input_data   in   write data
//   output_data  out  last value read; changes only when a read commits
//   ready        out  access complete, high in DONE only (registered)
module memory_block #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Counter only needs to hold LATENCY-1 down to 0.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nx;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  op_wr_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req_ok;
    logic                  last_cycle;
    logic                  accept;
    logic                  do_write;
    logic                  do_read;
    logic                  ready_nx;

    // A request is only legal with exactly one of read/write selected.
    assign req_ok     = en & (read ^ write);
    assign last_cycle = (state == BUSY) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // The access completes even if en already dropped; DONE is
                // then visited for one cycle and left on the next edge.
                if (cnt_q == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!en) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        accept   = 1'b0;
        do_write = 1'b0;
        do_read  = 1'b0;
        ready_nx = 1'b0;
        case (state)
            IDLE: accept = req_ok;
            BUSY: begin
                do_write = last_cycle & op_wr_q;
                do_read  = last_cycle & ~op_wr_q;
            end
            default: ;
        endcase
        // ready is registered so that it is high exactly while in DONE.
        ready_nx = (state_nx == DONE);
    end

    // Request latch and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            op_wr_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            addr_q  <= address;
            data_q  <= input_data;
            op_wr_q <= write;
            cnt_q   <= CNT_LOAD;
        end else if (state == BUSY && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Handshake output and read data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready       <= 1'b0;
            output_data <= '0;
        end else begin
            ready <= ready_nx;
            if (do_read) begin
                output_data <= mem[addr_q];
            end
        end
    end

    // Storage array: deliberately not reset. While rst_n is low the FSM is
    // held in IDLE, so no write can commit during reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_memory_block.sv
// tb/tb_memory_block.sv - self-checking bench for memory_block
module tb_memory_block;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       read;
    logic       write;
    logic [6:0] address;
    logic [7:0] input_data;
    logic [7:0] output_data;
    logic       ready;

    int vectors;
    int miscompares;

    logic [7:0] model_mem [128];
    logic [7:0] model_out;

    memory_block #(
        .ADDR_WIDTH(7),
        .DATA_WIDTH(8),
        .LATENCY   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .read       (read),
        .write      (write),
        .address    (address),
        .input_data (input_data),
        .output_data(output_data),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full handshake. hold = extra edges en stays high in DONE.
    // perturb scrambles the request inputs while BUSY.
    task automatic access(input bit is_wr, input logic [6:0] a, input logic [7:0] d,
                          input int hold, input bit perturb);
        en         = 1'b1;
        write      = is_wr;
        read       = !is_wr;
        address    = a;
        input_data = d;
        tick();
        check("busy_ready", {7'd0, ready}, 8'd0);
        check("busy_out", output_data, model_out);
        if (perturb) begin
            address    = 7'($urandom);
            input_data = 8'($urandom);
            read       = 1'($urandom);
            write      = 1'($urandom);
        end
        tick();
        if (is_wr) model_mem[a] = d;
        else       model_out    = model_mem[a];
        check("done_ready", {7'd0, ready}, 8'd1);
        check("done_out", output_data, model_out);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_ready", {7'd0, ready}, 8'd1);
            check("hold_out", output_data, model_out);
        end
        en    = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        tick();
        check("release_ready", {7'd0, ready}, 8'd0);
        check("release_out", output_data, model_out);
    endtask

    initial begin
        logic [7:0] old3;
        logic [7:0] d;
        logic [6:0] a;
        vectors     = 0;
        miscompares = 0;
        model_out   = 8'h00;
        rst_n       = 1'b0;
        en          = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        address     = '0;
        input_data  = '0;

        #2;
        check("reset_ready", {7'd0, ready}, 8'd0);
        check("reset_out", output_data, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill the RAM so every word has a known value.
        for (int i = 0; i < 128; i++) begin
            access(1'b1, 7'(i), 8'($urandom), 0, 1'b0);
        end

        // Write FF to address 1 with en held 3 edges, then read it back.
        access(1'b1, 7'd1, 8'hFF, 1, 1'b0);
        access(1'b0, 7'd1, 8'h00, 0, 1'b0);
        check("read_addr1", output_data, 8'hFF);

        // Boundary addresses.
        access(1'b1, 7'd0, 8'hA5, 0, 1'b0);
        access(1'b1, 7'd127, 8'h5A, 0, 1'b0);
        access(1'b0, 7'd0, 8'h00, 0, 1'b0);
        check("read_addr0", output_data, 8'hA5);
        access(1'b0, 7'd127, 8'h00, 0, 1'b0);
        check("read_addr127", output_data, 8'h5A);
        access(1'b0, 7'd126, 8'h00, 0, 1'b0);
        access(1'b0, 7'd2, 8'h00, 0, 1'b0);

        // Illegal selects: both high, then both low, 4 edges each.
        address    = 7'd5;
        input_data = ~model_mem[5];
        en         = 1'b1;
        for (int k = 0; k < 2; k++) begin
            read  = (k == 0);
            write = (k == 0);
            for (int c = 0; c < 4; c++) begin
                tick();
                check("illegal_ready", {7'd0, ready}, 8'd0);
                check("illegal_out", output_data, model_out);
            end
        end
        en = 1'b0;
        tick();
        access(1'b0, 7'd5, 8'h00, 0, 1'b0);

        // Inputs changed during BUSY must not affect the latched request.
        access(1'b1, 7'd9, 8'h3C, 0, 1'b1);
        access(1'b0, 7'd9, 8'h00, 0, 1'b1);
        check("stable_read", output_data, 8'h3C);

        // en dropped during BUSY: access completes, one DONE cycle, back to IDLE.
        en         = 1'b1;
        write      = 1'b1;
        address    = 7'd20;
        input_data = 8'hC3;
        tick();
        en    = 1'b0;
        write = 1'b0;
        tick();
        check("early_drop_done", {7'd0, ready}, 8'd1);
        tick();
        check("early_drop_idle", {7'd0, ready}, 8'd0);
        model_mem[20] = 8'hC3;
        access(1'b0, 7'd20, 8'h00, 0, 1'b0);

        // Reset in the middle of a write to address 3.
        old3       = model_mem[3];
        en         = 1'b1;
        write      = 1'b1;
        address    = 7'd3;
        input_data = ~old3;
        tick();
        rst_n = 1'b0;
        #1;
        check("midreset_ready", {7'd0, ready}, 8'd0);
        check("midreset_out", output_data, 8'h00);
        model_out = 8'h00;
        en    = 1'b0;
        write = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        access(1'b0, 7'd3, 8'h00, 0, 1'b0);
        check("midreset_addr3", output_data, old3);

        // Randomized traffic against the reference array.
        for (int n = 0; n < 150; n++) begin
            a = 7'($urandom);
            d = 8'($urandom);
            access(1'($urandom), a, d, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
